// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the round-robin stream multiplexer.
// Mode encodings plus channel-id width / wrap helpers used by top and arbiter.
package rr_stream_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Width of a channel id (chan_id_t) for a given channel count; never below one bit.
    function automatic int chan_id_width(input int nch);
        return (nch <= 2) ? 1 : $clog2(nch);
    endfunction

    // Next channel after id, wrapping from nch-1 back to 0 for any nch.
    function automatic int next_chan(input int id, input int nch);
        return (id + 1 >= nch) ? 0 : id + 1;
    endfunction

endpackage

// File: rtl/rr_stream_mux_arbiter.sv
// Rotate-priority search: first requester at or after ptr, wrapping mod NCH.
// Purely combinational; ptr is assumed to stay below NCH.
module rr_arbiter
    import rr_stream_mux_pkg::*;
#(
    parameter int NCH = 4,
    localparam int SELW = chan_id_width(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [NCH-1:0]  grant,
    output logic [SELW-1:0] id,
    output logic            found
);

    localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

    logic [SELW-1:0] cand [NCH];

    // cand[i] is the channel with i-th priority; one extra bit keeps ptr+i from overflowing.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_cand
            logic [SELW:0] sum;
            assign sum      = {1'b0, ptr} + (SELW+1)'(gi);
            assign cand[gi] = (sum >= NCH_W) ? SELW'(sum - NCH_W) : sum[SELW-1:0];
        end
    endgenerate

    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[cand[i]]) begin
                found          = 1'b1;
                id             = cand[i];
                grant[cand[i]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Winner comes from an external select or a fair round-robin arbiter.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int MODE  = MODE_RR,
    localparam int SELW = chan_id_width(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_ch
);

    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic [SELW-1:0]  out_ch_reg;
    logic [SELW-1:0]  ptr_reg;
    logic [SELW-1:0]  ptr_next;

    logic             load_en;
    logic             in_xfer;
    logic             win_valid;
    logic [SELW-1:0]  win_id;
    logic [NCH-1:0]   win_grant;
    logic [WIDTH-1:0] chan_data [NCH];

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            assign chan_data[gi] = in_data[gi*WIDTH +: WIDTH];
        end

        if (MODE == MODE_RR) begin : g_rr
            logic unused_sel;
            assign unused_sel = ^sel;

            rr_arbiter #(
                .NCH (NCH)
            ) u_arb (
                .req   (in_valid),
                .ptr   (ptr_reg),
                .grant (win_grant),
                .id    (win_id),
                .found (win_valid)
            );
        end else begin : g_sel
            localparam logic [SELW:0] NCH_W = (SELW+1)'(NCH);

            // An out-of-range select never wins, even when NCH is not a power of two.
            always_comb begin
                win_valid = 1'b0;
                win_id    = sel;
                win_grant = '0;
                if ({1'b0, sel} < NCH_W) begin
                    if (in_valid[sel]) begin
                        win_valid      = 1'b1;
                        win_grant[sel] = 1'b1;
                    end
                end
            end
        end
    endgenerate

    assign load_en  = !out_valid_reg || out_ready;
    assign in_xfer  = load_en && win_valid;
    // Held low throughout reset so no producer believes a beat was taken.
    assign in_ready = (rst_n && load_en) ? win_grant : '0;

    always_comb begin
        ptr_next = ptr_reg;
        if (in_xfer && (MODE == MODE_RR)) begin
            ptr_next = SELW'(next_chan(int'(win_id), NCH));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            ptr_reg       <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (in_xfer) begin
                out_data_reg  <= chan_data[win_id];
                out_ch_reg    <= win_id;
                out_valid_reg <= 1'b1;
            end else if (out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_ch    = out_ch_reg;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Self-checking bench: four mux instances (RR/SEL x 4/3 channels) against a beat-level model.
module tb_rr_stream_mux;
    import rr_stream_mux_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic [3:0] v_rr4, v_sel4;
    logic [31:0] d_rr4, d_sel4;
    logic [1:0] s_rr4, s_sel4;
    logic r_rr4, r_sel4;
    logic [3:0] rdy_rr4, rdy_sel4;
    logic [7:0] od_rr4, od_sel4;
    logic ov_rr4, ov_sel4;
    logic [1:0] oc_rr4, oc_sel4;

    logic [2:0] v_rr3, v_sel3;
    logic [23:0] d_rr3, d_sel3;
    logic [1:0] s_rr3, s_sel3;
    logic r_rr3, r_sel3;
    logic [2:0] rdy_rr3, rdy_sel3;
    logic [7:0] od_rr3, od_sel3;
    logic ov_rr3, ov_sel3;
    logic [1:0] oc_rr3, oc_sel3;

    rr_stream_mux #(.WIDTH(8), .NCH(4), .MODE(MODE_RR)) u_rr4 (
        .clk(clk), .rst_n(rst_n), .in_data(d_rr4), .in_valid(v_rr4), .in_ready(rdy_rr4),
        .sel(s_rr4), .out_data(od_rr4), .out_valid(ov_rr4), .out_ready(r_rr4), .out_ch(oc_rr4));
    rr_stream_mux #(.WIDTH(8), .NCH(4), .MODE(MODE_SEL)) u_sel4 (
        .clk(clk), .rst_n(rst_n), .in_data(d_sel4), .in_valid(v_sel4), .in_ready(rdy_sel4),
        .sel(s_sel4), .out_data(od_sel4), .out_valid(ov_sel4), .out_ready(r_sel4), .out_ch(oc_sel4));
    rr_stream_mux #(.WIDTH(8), .NCH(3), .MODE(MODE_RR)) u_rr3 (
        .clk(clk), .rst_n(rst_n), .in_data(d_rr3), .in_valid(v_rr3), .in_ready(rdy_rr3),
        .sel(s_rr3), .out_data(od_rr3), .out_valid(ov_rr3), .out_ready(r_rr3), .out_ch(oc_rr3));
    rr_stream_mux #(.WIDTH(8), .NCH(3), .MODE(MODE_SEL)) u_sel3 (
        .clk(clk), .rst_n(rst_n), .in_data(d_sel3), .in_valid(v_sel3), .in_ready(rdy_sel3),
        .sel(s_sel3), .out_data(od_sel3), .out_valid(ov_sel3), .out_ready(r_sel3), .out_ch(oc_sel3));

    int n_checks = 0;
    int n_fail   = 0;

    // Beat-level reference: one output slot per instance and a rotating priority start.
    int          nch_m  [4] = '{4, 4, 3, 3};
    int          mode_m [4] = '{MODE_RR, MODE_SEL, MODE_RR, MODE_SEL};
    bit          m_valid[4];
    int          m_data [4];
    int          m_ch   [4];
    int          m_ptr  [4];
    logic [3:0]  cur_v  [4];
    logic [31:0] cur_dat[4];
    int          cur_s  [4];
    bit          cur_r  [4];
    logic [3:0]  e_rdy  [4];
    logic [3:0]  a_rdy  [4];

    function automatic int m_winner(input int d);
        int n;
        n = nch_m[d];
        if (mode_m[d] == MODE_RR) begin
            for (int j = 0; j < n; j++) begin
                if (cur_v[d][(m_ptr[d] + j) % n]) return (m_ptr[d] + j) % n;
            end
            return -1;
        end
        if (cur_s[d] < n && cur_v[d][cur_s[d]]) return cur_s[d];
        return -1;
    endfunction

    function automatic logic [3:0] m_ready(input int d);
        int w;
        w = m_winner(d);
        if ((!m_valid[d] || cur_r[d]) && w >= 0) return 4'(1 << w);
        return 4'd0;
    endfunction

    function automatic void m_clock();
        for (int d = 0; d < 4; d++) begin
            int w;
            w = m_winner(d);
            if ((!m_valid[d] || cur_r[d]) && w >= 0) begin
                m_data[d]  = int'((cur_dat[d] >> (8 * w)) & 32'hFF);
                m_ch[d]    = w;
                m_valid[d] = 1'b1;
                if (mode_m[d] == MODE_RR) m_ptr[d] = (w + 1) % nch_m[d];
            end else if (m_valid[d] && cur_r[d]) begin
                m_valid[d] = 1'b0;
            end
        end
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 4; d++) begin
            m_valid[d] = 1'b0; m_data[d] = 0; m_ch[d] = 0; m_ptr[d] = 0;
        end
    endfunction

    task automatic drive(input int d, input logic [3:0] v, input logic [31:0] dat,
                         input int s, input bit r);
        cur_v[d] = v; cur_dat[d] = dat; cur_s[d] = s; cur_r[d] = r;
        case (d)
            0: begin v_rr4 = v; d_rr4 = dat; s_rr4 = 2'(s); r_rr4 = r; end
            1: begin v_sel4 = v; d_sel4 = dat; s_sel4 = 2'(s); r_sel4 = r; end
            2: begin v_rr3 = v[2:0]; d_rr3 = dat[23:0]; s_rr3 = 2'(s); r_rr3 = r; end
            default: begin v_sel3 = v[2:0]; d_sel3 = dat[23:0]; s_sel3 = 2'(s); r_sel3 = r; end
        endcase
    endtask

    task automatic idle_all();
        for (int d = 0; d < 4; d++) drive(d, 4'h0, 32'h0, 0, 1'b1);
    endtask

    function automatic logic [3:0] obs_rdy(input int d);
        case (d)
            0: return rdy_rr4;
            1: return rdy_sel4;
            2: return {1'b0, rdy_rr3};
            default: return {1'b0, rdy_sel3};
        endcase
    endfunction

    function automatic logic obs_valid(input int d);
        case (d)
            0: return ov_rr4;
            1: return ov_sel4;
            2: return ov_rr3;
            default: return ov_sel3;
        endcase
    endfunction

    function automatic logic [7:0] obs_data(input int d);
        case (d)
            0: return od_rr4;
            1: return od_sel4;
            2: return od_rr3;
            default: return od_sel3;
        endcase
    endfunction

    function automatic logic [1:0] obs_ch(input int d);
        case (d)
            0: return oc_rr4;
            1: return oc_sel4;
            2: return oc_rr3;
            default: return oc_sel3;
        endcase
    endfunction

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        #1;
        for (int d = 0; d < 4; d++) begin
            e_rdy[d] = m_ready(d);
            a_rdy[d] = obs_rdy(d);
        end
        @(posedge clk);
        m_clock();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int d = 0; d < 4; d++) drive(d, 4'hF, 32'h44332211, 0, 1'b1);
        m_reset();
        repeat (2) @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (obs_valid(d) !== 1'b0 || obs_data(d) !== 8'h00 || obs_ch(d) !== 2'd0) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: got v=%b d=%h ch=%0d, expected all zero",
                         d, obs_valid(d), obs_data(d), obs_ch(d));
            end
            n_checks++;
            if (obs_rdy(d) !== 4'h0) begin
                n_fail++;
                $display("FAIL reset_ready[%0d]: got %b expected 0000", d, obs_rdy(d));
            end
        end
        idle_all();
        rst_n = 1'b1;
        $display("[%0t] reset released", $time);
    endtask

    task automatic test_rr_all_valid();
        idle_all();
        drive(0, 4'hF, 32'hA3A2A1A0, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step();
            $display("[%0t] rr4 beat ch=%0d data=%02h", $time, oc_rr4, od_rr4);
            n_checks++;
            if (a_rdy[0] !== 4'(1 << (i % 4))) begin
                n_fail++;
                $display("FAIL rr_all_ready[%0d]: got %b expected %b", i, a_rdy[0], 4'(1 << (i % 4)));
            end
            n_checks++;
            if (ov_rr4 !== 1'b1 || oc_rr4 !== 2'(i % 4) || od_rr4 !== 8'(8'hA0 + i % 4)) begin
                n_fail++;
                $display("FAIL rr_all_beat[%0d]: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                         i, ov_rr4, oc_rr4, od_rr4, i % 4, 8'(8'hA0 + i % 4));
            end
        end
    endtask

    task automatic test_rr_skip();
        logic [3:0] vseq [3];
        int         chs  [3];
        vseq = '{4'b1100, 4'b1100, 4'b0001};
        chs  = '{2, 3, 0};
        for (int i = 0; i < 3; i++) begin
            drive(0, vseq[i], 32'hB3B2B1B0, 0, 1'b1);
            step();
            $display("[%0t] rr4 beat ch=%0d data=%02h", $time, oc_rr4, od_rr4);
            n_checks++;
            if (a_rdy[0] !== 4'(1 << chs[i]) || oc_rr4 !== 2'(chs[i])) begin
                n_fail++;
                $display("FAIL rr_skip[%0d]: got ready=%b ch=%0d expected ready=%b ch=%0d",
                         i, a_rdy[0], oc_rr4, 4'(1 << chs[i]), chs[i]);
            end
        end
        drive(0, 4'h0, 32'h0, 0, 1'b1);
        repeat (2) step();
        n_checks++;
        if (ov_rr4 !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_drain: got out_valid=%b expected 0", ov_rr4);
        end
    endtask

    task automatic test_stall();
        logic [7:0] hold_d;
        logic [1:0] hold_c;
        drive(0, 4'hF, 32'hC3C2C1C0, 0, 1'b1);
        step();
        hold_d = od_rr4;
        hold_c = oc_rr4;
        n_checks++;
        if (ov_rr4 !== 1'b1 || oc_rr4 !== 2'(m_ch[0]) || od_rr4 !== 8'(m_data[0])) begin
            n_fail++;
            $display("FAIL stall_load: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                     ov_rr4, oc_rr4, od_rr4, m_ch[0], 8'(m_data[0]));
        end
        drive(0, 4'hF, 32'h5A5A5A5A, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (a_rdy[0] !== 4'h0 || ov_rr4 !== 1'b1 || od_rr4 !== hold_d || oc_rr4 !== hold_c) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got ready=%b v=%b d=%h ch=%0d expected 0000 1 %h %0d",
                         i, a_rdy[0], ov_rr4, od_rr4, oc_rr4, hold_d, hold_c);
            end
        end
        drive(0, 4'hF, 32'hC3C2C1C0, 0, 1'b1);
        step();
        $display("[%0t] rr4 beat ch=%0d data=%02h", $time, oc_rr4, od_rr4);
        n_checks++;
        if (a_rdy[0] !== e_rdy[0] || oc_rr4 !== 2'(m_ch[0]) || od_rr4 !== 8'(m_data[0])) begin
            n_fail++;
            $display("FAIL stall_resume: got ready=%b ch=%0d d=%h expected ready=%b ch=%0d d=%h",
                     a_rdy[0], oc_rr4, od_rr4, e_rdy[0], m_ch[0], 8'(m_data[0]));
        end
    endtask

    task automatic test_sel();
        idle_all();
        drive(1, 4'b0110, 32'hD3D2D1D0, 1, 1'b1);
        step();
        $display("[%0t] sel4 beat ch=%0d data=%02h", $time, oc_sel4, od_sel4);
        n_checks++;
        if (a_rdy[1] !== 4'b0010 || ov_sel4 !== 1'b1 || oc_sel4 !== 2'd1 || od_sel4 !== 8'hD1) begin
            n_fail++;
            $display("FAIL sel_hit: got ready=%b v=%b ch=%0d d=%h expected 0010 1 1 d1",
                     a_rdy[1], ov_sel4, oc_sel4, od_sel4);
        end
        drive(1, 4'b0110, 32'hD3D2D1D0, 3, 1'b1);
        step();
        n_checks++;
        if (a_rdy[1] !== 4'b0000 || ov_sel4 !== 1'b0) begin
            n_fail++;
            $display("FAIL sel_miss: got ready=%b v=%b expected 0000 0", a_rdy[1], ov_sel4);
        end
    endtask

    task automatic test_nch3();
        idle_all();
        drive(3, 4'b0111, 32'h00C2C1C0, 3, 1'b1);
        repeat (2) step();
        n_checks++;
        if (a_rdy[3] !== 4'b0000 || ov_sel3 !== 1'b0) begin
            n_fail++;
            $display("FAIL sel3_oor: got ready=%b v=%b expected 0000 0", a_rdy[3], ov_sel3);
        end
        drive(3, 4'b0111, 32'h00C2C1C0, 2, 1'b1);
        step();
        n_checks++;
        if (a_rdy[3] !== 4'b0100 || oc_sel3 !== 2'd2 || od_sel3 !== 8'hC2) begin
            n_fail++;
            $display("FAIL sel3_top: got ready=%b ch=%0d d=%h expected 0100 2 c2", a_rdy[3], oc_sel3, od_sel3);
        end
        drive(3, 4'h0, 32'h0, 0, 1'b1);
        drive(2, 4'b0111, 32'h00B2B1B0, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            $display("[%0t] rr3 beat ch=%0d data=%02h", $time, oc_rr3, od_rr3);
            n_checks++;
            if (oc_rr3 !== 2'(i % 3) || od_rr3 !== 8'(8'hB0 + i % 3) || ov_rr3 !== 1'b1) begin
                n_fail++;
                $display("FAIL rr3_wrap[%0d]: got ch=%0d d=%h v=%b expected ch=%0d d=%h v=1",
                         i, oc_rr3, od_rr3, ov_rr3, i % 3, 8'(8'hB0 + i % 3));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            for (int d = 0; d < 4; d++) begin
                drive(d, 4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3),
                      ($urandom_range(0, 3) != 0));
            end
            step();
            for (int d = 0; d < 4; d++) begin
                n_checks++;
                if (a_rdy[d] !== e_rdy[d]) begin
                    n_fail++;
                    $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", d, c, a_rdy[d], e_rdy[d]);
                end
                n_checks++;
                if (obs_valid(d) !== m_valid[d] || obs_ch(d) !== 2'(m_ch[d]) ||
                    obs_data(d) !== 8'(m_data[d])) begin
                    n_fail++;
                    $display("FAIL rand_out[%0d] cyc %0d: got v=%b ch=%0d d=%h expected v=%b ch=%0d d=%h",
                             d, c, obs_valid(d), obs_ch(d), obs_data(d), m_valid[d], m_ch[d], 8'(m_data[d]));
                end
            end
        end
        $display("[%0t] random phase done", $time);
    endtask

    task automatic test_reset_mid();
        idle_all();
        drive(0, 4'hF, 32'hE3E2E1E0, 0, 1'b1);
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ov_rr4 !== 1'b0 || od_rr4 !== 8'h00 || oc_rr4 !== 2'd0 || rdy_rr4 !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_mid: got v=%b d=%h ch=%0d ready=%b expected all zero",
                     ov_rr4, od_rr4, oc_rr4, rdy_rr4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        step();
        $display("[%0t] rr4 beat ch=%0d data=%02h", $time, oc_rr4, od_rr4);
        n_checks++;
        if (ov_rr4 !== 1'b1 || oc_rr4 !== 2'd0 || od_rr4 !== 8'hE0) begin
            n_fail++;
            $display("FAIL reset_first_grant: got v=%b ch=%0d d=%h expected 1 0 e0", ov_rr4, oc_rr4, od_rr4);
        end
    endtask

    initial begin
        test_reset();
        test_rr_all_valid();
        test_rr_skip();
        test_stall();
        test_sel();
        test_nch3();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-channel, W-bit streaming multiplexer with a registered output stage and valid/ready handshakes on every channel. It is the sequential successor to the team's combinational 4:1 mux. It arbitrates among up to NCH producers, either by external select or by fair round-robin, and delivers one beat per cycle to a single consumer. It sits between multiple datapath sources and one shared sink, such as a shared bus or serialiser.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- NCH, 4, number of input channels (2..16)
- MODE, 1, 0 = MODE_SEL (external select), 1 = MODE_RR (round-robin)
- SELW, $clog2(NCH), select/channel-id width (derived, not overridden)

- clk  in  1  rising-edge clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- in_valid  in  NCH  per-channel valid
- in_ready  out  NCH  per-channel ready; at most one bit high per cycle
- sel  in  SELW  channel select, used only in MODE_SEL
- out_data  out  WIDTH  registered output data
- out_valid  out  1  registered output valid
- out_ready  in  1  consumer ready
- out_ch  out  SELW  channel id of the beat currently in out_data

## Operation
- Transfer on input k: in_valid[k] & in_ready[k] at a rising edge. Transfer on output: out_valid & out_ready.
- load_en = !out_valid | out_ready. The output register can accept a beat this cycle.
- Winner selection:
  - MODE_SEL: the candidate is sel. The winner is sel if sel < NCH and in_valid[sel]. Otherwise there is no winner. An out-of-range sel never transfers.
  - MODE_RR: the winner is the first channel with in_valid set, searching from ptr upward and wrapping mod NCH.
- in_ready[k] = load_en & (k == winner). It is combinational.
- A valid producer may see in_ready depend on in_valid. Producers must not make in_valid depend on in_ready.
- On input transfer:
  - out_data ← in_data[winner], out_ch ← winner, out_valid ← 1.
  - MODE_RR only: ptr ← (winner+1) mod NCH.
- On output transfer with no input transfer in the same cycle: out_valid ← 0. out_data and out_ch hold their values.
- When out_valid & !out_ready (stall), out_data, out_ch, out_valid and ptr all hold. in_ready is all-zero.
- ptr advances only on an input transfer. Idle cycles and stalls never move it.
- Non-power-of-two NCH: ptr wraps from NCH-1 to 0. Values ≥ NCH are never reached.

## Timing
- Reset (asynchronous assert, synchronous-to-clk deassert by the system): out_valid=0, out_data=0, out_ch=0, ptr=0.
- in_ready is 0 during reset. While rst_n is low it is forced to 0, overriding load_en.
- Latency: a beat accepted at edge t appears on out_data/out_valid immediately after edge t.
- Throughput: one beat per cycle with out_ready held high. There are no bubbles on a simultaneous output pop and input push.
- Reset asserted mid-transfer drops the in-flight beat. No partial state survives.
- A beat held in the output register under stall must not change until it is popped.

## Structure
- Package rr_stream_mux_pkg holds:
  - MODE_SEL=0 and MODE_RR=1 constants.
  - A chan_id_t typedef helper function for SELW.
- Sub-module rr_arbiter (NCH req in, ptr in, one-hot grant plus encoded id out) provides the rotate-priority search. It is used only when MODE==MODE_RR, selected by a generate branch.
- The top level holds load_en, the output register, ptr and the in_ready decode.

## Test plan
- MODE_RR, NCH=4, all in_valid=1, out_ready=1, in_data[k]=8'hA0+k for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3 and out_data A0..A3 repeated, no gaps.
- MODE_RR, only ch2 and ch3 valid, then ch0 becomes valid after ch3 is granted -> grants go 2,3,0. The pointer skips idle channels and wraps correctly.
- Stall: out_valid=1, out_ready=0 for 3 cycles while all channels are valid -> in_ready=0000, and out_data, out_ch and ptr are unchanged. On out_ready=1, the next grant is from ptr.
- MODE_SEL, sel=1 with in_valid=4'b0110 -> only in_ready[1] is high and out_ch=1. With sel=3 (in_valid[3]=0) -> no transfer, and out_valid falls after the pop.
- NCH=3 in MODE_SEL with sel=3 (out of range) -> no transfer. In MODE_RR, NCH=3 all valid -> out_ch 0,1,2,0.
- Assert rst_n=0 mid-stream with out_valid=1 -> out_valid, out_data, out_ch and in_ready go to 0 immediately. After release, the first RR grant is ch0.
